// File: rtl/dither_dpwm_gen_pkg.sv
// Shared definitions for the dithered DPWM: default geometry and the dither-order bit reversal.
package dither_dpwm_gen_pkg;

  localparam int DEF_CNT_W  = 6;
  localparam int DEF_DITH_W = 3;
  localparam int DEF_DT_W   = 4;

  localparam int PERIOD   = 1 << DEF_CNT_W;
  localparam int DCYC     = 1 << DEF_DITH_W;
  localparam int BR_MAX_W = 16;

  // Reverses the low w bits of v; bits at or above w come back as 0.
  function automatic logic [BR_MAX_W-1:0] bitrev(input logic [BR_MAX_W-1:0] v, input int w);
    logic [BR_MAX_W-1:0] rev;
    rev = '0;
    for (int i = 0; i < BR_MAX_W; i++) begin
      for (int j = 0; j < BR_MAX_W; j++) begin
        if (i + j == w - 1) rev[i] = v[j];
      end
    end
    return rev;
  endfunction

endpackage

// File: rtl/dpwm_deadtime.sv
// Complementary gate drive with counter-based dead time, fed by the look-ahead PWM value
// so hs_out/ls_out are registered in the same cycle as the registered PWM they follow.
module dpwm_deadtime #(
  parameter int DT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            pwm_nxt,
  input  logic [DT_W-1:0] dt,
  output logic            hs_out,
  output logic            ls_out
);

  localparam int            RW    = DT_W + 1;
  localparam logic [RW-1:0] L_SAT = {1'b1, {DT_W{1'b0}}};

  logic          r_lvl;
  logic [RW-1:0] r_run_len;
  logic          r_hs;
  logic          r_ls;
  logic [RW-1:0] w_len_nxt;
  logic          w_gate;

  // Length of the current constant-level run including the coming cycle; 0 means no run yet.
  always_comb begin
    w_len_nxt = '0;
    if (en) begin
      if (pwm_nxt != r_lvl)        w_len_nxt = RW'(1);
      else if (r_run_len == L_SAT) w_len_nxt = L_SAT;
      else                         w_len_nxt = r_run_len + 1'b1;
    end
  end

  assign w_gate = (w_len_nxt > {1'b0, dt});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lvl     <= 1'b0;
      r_run_len <= '0;
      r_hs      <= 1'b0;
      r_ls      <= 1'b0;
    end else begin
      r_lvl     <= en & pwm_nxt;
      r_run_len <= w_len_nxt;
      r_hs      <= en & pwm_nxt & w_gate;
      r_ls      <= en & ~pwm_nxt & w_gate;
    end
  end

  assign hs_out = r_hs;
  assign ls_out = r_ls;

endmodule

// File: rtl/dither_dpwm_gen.sv
// Dithered counter-comparator DPWM: MSB field sets the on-time, LSB field adds one cycle in
// bit-reversed dither periods; commands latch at period boundaries; dead time in dpwm_deadtime.
module dither_dpwm_gen
  import dither_dpwm_gen_pkg::*;
#(
  parameter int CNT_W  = $clog2(PERIOD),
  parameter int DITH_W = $clog2(DCYC),
  parameter int DT_W   = DEF_DT_W,
  parameter int DUTY_W = CNT_W + DITH_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DUTY_W-1:0] duty_in,
  input  logic [DT_W-1:0]   dt_in,
  output logic              pwm_raw,
  output logic              hs_out,
  output logic              ls_out,
  output logic              period_start,
  output logic [DITH_W-1:0] dith_idx
);

  localparam logic [CNT_W-1:0] L_CNT_MAX = {CNT_W{1'b1}};

  logic              r_run;
  logic [CNT_W-1:0]  r_cnt;
  logic [DITH_W-1:0] r_idx;
  logic [DUTY_W-1:0] r_duty;
  logic [DT_W-1:0]   r_dt;
  logic              r_pwm;

  logic              w_start;
  logic              w_wrap;
  logic              w_load;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DITH_W-1:0] w_idx_nxt;
  logic [DUTY_W-1:0] w_duty_nxt;
  logic [DT_W-1:0]   w_dt_nxt;
  logic [CNT_W-1:0]  w_msb;
  logic [DITH_W-1:0] w_lsb;
  logic [DITH_W-1:0] w_rev;
  logic              w_extra;
  logic [CNT_W:0]    w_eff;
  logic              w_pwm_nxt;

  // The first enabled edge only arms the generator: counter stays at 0 and the command is
  // taken straight from the inputs, so period 0 already runs with the current command.
  assign w_start   = en & ~r_run;
  assign w_wrap    = en & r_run & (r_cnt == L_CNT_MAX);
  assign w_load    = w_start | w_wrap;

  assign w_cnt_nxt = (en && r_run) ? r_cnt + 1'b1 : '0;
  assign w_idx_nxt = !en ? '0 : (w_wrap ? r_idx + 1'b1 : r_idx);
  assign w_duty_nxt = w_load ? duty_in : r_duty;
  assign w_dt_nxt   = w_load ? dt_in : r_dt;

  // Look-ahead compare: everything below describes the cycle after the coming edge.
  assign w_msb     = w_duty_nxt[DUTY_W-1:DITH_W];
  assign w_lsb     = w_duty_nxt[DITH_W-1:0];
  assign w_rev     = DITH_W'(bitrev(BR_MAX_W'(w_idx_nxt), DITH_W));
  assign w_extra   = (w_rev < w_lsb);
  assign w_eff     = {1'b0, w_msb} + {{CNT_W{1'b0}}, w_extra};
  assign w_pwm_nxt = en & ({1'b0, w_cnt_nxt} < w_eff);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run  <= 1'b0;
      r_cnt  <= '0;
      r_idx  <= '0;
      r_duty <= '0;
      r_dt   <= '0;
      r_pwm  <= 1'b0;
    end else begin
      r_run <= en;
      r_cnt <= w_cnt_nxt;
      r_idx <= w_idx_nxt;
      r_pwm <= w_pwm_nxt;
      if (w_load) begin
        r_duty <= duty_in;
        r_dt   <= dt_in;
      end
    end
  end

  dpwm_deadtime #(
    .DT_W (DT_W)
  ) u_deadtime (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .pwm_nxt (w_pwm_nxt),
    .dt      (w_dt_nxt),
    .hs_out  (hs_out),
    .ls_out  (ls_out)
  );

  assign pwm_raw      = r_pwm;
  assign period_start = r_run & (r_cnt == '0);
  assign dith_idx     = r_idx;

endmodule

// File: tb/tb_dither_dpwm_gen.sv
// Bench for dither_dpwm_gen at CNT_W=4, DITH_W=3, DT_W=4: period-level reference model plus
// hand-computed per-period pulse counts from the test plan.
module tb_dither_dpwm_gen;

  localparam int CNT_W  = 4;
  localparam int DITH_W = 3;
  localparam int DT_W   = 4;
  localparam int PER    = 1 << CNT_W;
  localparam int DC     = 1 << DITH_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b0;
  logic [6:0]        duty_in = '0;
  logic [DT_W-1:0]   dt_in = '0;
  logic              pwm_raw;
  logic              hs_out;
  logic              ls_out;
  logic              period_start;
  logic [DITH_W-1:0] dith_idx;

  int n_checks = 0;
  int n_fail   = 0;

  dither_dpwm_gen #(
    .CNT_W  (CNT_W),
    .DITH_W (DITH_W),
    .DT_W   (DT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .duty_in      (duty_in),
    .dt_in        (dt_in),
    .pwm_raw      (pwm_raw),
    .hs_out       (hs_out),
    .ls_out       (ls_out),
    .period_start (period_start),
    .dith_idx     (dith_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_active = 0, m_c = 0, m_k = 0, m_duty = 0, m_dt = 0, m_eff = 0;
  int e_pwm = 0, e_hs = 0, e_ls = 0, e_ps = 0, e_idx = 0;
  bit hist[$];

  function automatic int rev3(input int v);
    int r = 0;
    for (int b = 0; b < DITH_W; b++) if (((v >> b) & 1) != 0) r |= 1 << (DITH_W - 1 - b);
    return r;
  endfunction

  // True when the last dt+1 PWM cycles of this run all had level v.
  function automatic bit steady(input bit v, input int dt);
    if (hist.size() < dt + 1) return 1'b0;
    for (int i = 0; i <= dt; i++) if (hist[hist.size() - 1 - i] != v) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst || !en) begin
      m_active = 0;
    end else if (m_active == 0) begin
      m_active = 1; m_c = 0; m_k = 0;
      m_duty = int'(duty_in); m_dt = int'(dt_in);
      hist.delete();
    end else begin
      m_c++;
      if (m_c == PER) begin
        m_c = 0; m_k = (m_k + 1) % DC;
        m_duty = int'(duty_in); m_dt = int'(dt_in);
      end
    end
    if (m_active != 0) begin
      m_eff = m_duty / DC + ((rev3(m_k) < m_duty % DC) ? 1 : 0);
      e_pwm = (m_c < m_eff) ? 1 : 0;
      hist.push_back(e_pwm != 0);
      if (hist.size() > 64) void'(hist.pop_front());
      e_hs  = (e_pwm != 0 && steady(1'b1, m_dt)) ? 1 : 0;
      e_ls  = (e_pwm == 0 && steady(1'b0, m_dt)) ? 1 : 0;
      e_ps  = (m_c == 0) ? 1 : 0;
      e_idx = m_k;
    end else begin
      e_pwm = 0; e_hs = 0; e_ls = 0; e_ps = 0; e_idx = 0;
      hist.delete();
    end
  end

  always @(negedge clk) begin
    chk("pwm_raw", 32'(pwm_raw), e_pwm);
    chk("hs_out", 32'(hs_out), e_hs);
    chk("ls_out", 32'(ls_out), e_ls);
    chk("period_start", 32'(period_start), e_ps);
    chk("dith_idx", 32'(dith_idx), e_idx);
    chk("overlap", 32'(hs_out & ls_out), 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  // Advance at least one cycle, then until the model sits at counter c of dither slot idx (-1: any).
  task automatic wait_pos(input int idx, input int c);
    int n = 0;
    step();
    while (!(m_active != 0 && m_c == c && (idx < 0 || m_k == idx)) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_timeout: slot %0d count %0d not reached", idx, c);
    end
  endtask

  task automatic measure(input int n, output int pw, output int hs, output int ls);
    pw = 0; hs = 0; ls = 0;
    for (int i = 0; i < n; i++) begin
      pw += int'(pwm_raw);
      hs += int'(hs_out);
      ls += int'(ls_out);
      step();
    end
  endtask

  int pw, hs, ls, pw2, hs2, ls2, tot, quiet;
  int exp_hi[8];

  initial begin
    exp_hi = '{6, 5, 6, 5, 6, 5, 5, 5};

    // Reset state
    repeat (3) step();
    chk("rst_pwm", 32'(pwm_raw), 0);
    chk("rst_ls", 32'(ls_out), 0);
    chk("rst_ps", 32'(period_start), 0);
    chk("rst_idx", 32'(dith_idx), 0);

    // duty 40, dt 0: first period after enable uses the current command
    rst = 1'b0; en = 1'b1; duty_in = 7'd40; dt_in = 4'd0;
    wait_pos(-1, 0);
    measure(16, pw, hs, ls);
    chk("d40_high", pw, 5);
    chk("d40_hs", hs, 5);
    chk("d40_ls", ls, 11);

    // duty 43: dither slots 0,2,4 get the extra cycle
    duty_in = 7'd43;
    wait_pos(0, 0);
    tot = 0;
    for (int p = 0; p < 8; p++) begin
      measure(16, pw, hs, ls);
      chk($sformatf("d43_slot%0d", p), pw, exp_hi[p]);
      tot += pw;
    end
    chk("d43_total", tot, 43);

    // duty 43, dt 2, slot 0: hs c=2..5, ls c=8..15
    dt_in = 4'd2;
    wait_pos(0, 0);
    measure(16, pw, hs, ls);
    chk("dt2_high", pw, 6);
    chk("dt2_hs", hs, 4);
    chk("dt2_ls", ls, 8);

    // duty 127, dt 3: one 1-cycle low pulse per dither cycle, swallowed by dead time
    duty_in = 7'd127; dt_in = 4'd3;
    wait_pos(0, 0);
    measure(128, pw, hs, ls);
    chk("d127_high", pw, 127);
    chk("d127_hs", hs, 124);
    chk("d127_ls", ls, 0);

    // Mid-period command change only affects the next period
    duty_in = 7'd40; dt_in = 4'd0;
    wait_pos(-1, 0);
    wait_pos(-1, 0);
    measure(7, pw, hs, ls);
    duty_in = 7'd16;
    measure(9, pw2, hs2, ls2);
    chk("chg_cur", pw + pw2, 5);
    measure(16, pw, hs, ls);
    chk("chg_next", pw, 2);

    // Zero duty after enable: ls rises dt cycles into the period
    en = 1'b0;
    step();
    duty_in = 7'd0; dt_in = 4'd3; en = 1'b1;
    wait_pos(-1, 0);
    measure(16, pw, hs, ls);
    chk("d0_high", pw, 0);
    chk("d0_ls", ls, 13);

    // Randomised commands with occasional enable drops and reset pulses
    for (int s = 0; s < 70; s++) begin
      int sel, len, r;
      sel = $urandom_range(0, 9);
      if (sel == 0)      duty_in = 7'd0;
      else if (sel == 1) duty_in = 7'd127;
      else if (sel == 2) duty_in = 7'($urandom_range(0, 15) * 8);
      else               duty_in = 7'($urandom_range(0, 127));
      dt_in = 4'($urandom_range(0, 15));
      len = $urandom_range(8, 60);
      for (int i = 0; i < len; i++) begin
        r   = $urandom_range(0, 199);
        rst = (r == 0);
        en  = !(r >= 1 && r <= 3);
        step();
      end
      rst = 1'b0; en = 1'b1;
    end

    // Reset at c=9 in a nonzero dither slot, then hold disabled
    duty_in = 7'd40; dt_in = 4'd0; en = 1'b1; rst = 1'b0;
    wait_pos(3, 9);
    rst = 1'b1;
    step();
    chk("mid_rst_pwm", 32'(pwm_raw), 0);
    chk("mid_rst_hs", 32'(hs_out), 0);
    chk("mid_rst_ls", 32'(ls_out), 0);
    chk("mid_rst_ps", 32'(period_start), 0);
    chk("mid_rst_idx", 32'(dith_idx), 0);
    rst = 1'b0; en = 1'b0;
    quiet = 0;
    for (int i = 0; i < 40; i++) begin
      quiet += int'(pwm_raw) + int'(hs_out) + int'(ls_out) + int'(period_start);
      step();
    end
    chk("disabled_quiet", quiet, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
